// File: rtl/spart_rx.sv
// SPART receiver: deserialises 8N1 frames from rxd using the shared 16x
// baud-generator enable, and presents the byte through a holding register
// with rda / frame_err / overrun status toward the bus interface.
module spart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_en,
  input  logic                 rxd,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  logic [1:0]           sync;
  logic                 rxs;
  logic [2:0]           state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 done;

  assign rxs = sync[1];

  // Stop-bit sample tick: the frame is complete on this cycle.
  assign done = baud_en && (state == S_STOP) && (tick_cnt == FULL_M1);

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], rxd};
  end

  // Frame FSM; only moves on oversample ticks, samples mid-bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else if (baud_en) begin
      case (state)
        S_IDLE: begin
          if (!rxs) begin
            state    <= S_START;
            tick_cnt <= '0;
          end
        end
        S_START: begin
          if (tick_cnt == HALF_M1) begin
            // Line must still be low at mid start bit, else it was a glitch.
            if (!rxs) begin
              state    <= S_DATA;
              tick_cnt <= '0;
              bit_idx  <= '0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tick_cnt == FULL_M1) begin
            shreg    <= {rxs, shreg[DATA_BITS-1:1]};
            tick_cnt <= '0;
            if (bit_idx == LAST_BIT) state <= S_STOP;
            else                     bit_idx <= bit_idx + 1'b1;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (tick_cnt == FULL_M1) begin
            tick_cnt <= '0;
            // A low stop bit may be a break: wait for the line to recover.
            state    <= rxs ? S_IDLE : S_WAIT_HIGH;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (rxs) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Holding register and status; a completing frame wins over rd_ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data   <= '0;
      rda       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else if (done) begin
      rx_data   <= shreg;
      rda       <= 1'b1;
      frame_err <= ~rxs;
      // Unread byte being replaced -> overrun; a same-cycle read consumed it.
      overrun   <= rda && !rd_ack;
    end else if (rd_ack && rda) begin
      rda       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end
  end

endmodule
